// File: rtl/sprite_pkg.sv
// Shared screen/colour constants and bundle types
// for the sprite layer and its helpers.
package sprite_pkg;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int CRD_W = 10;
  localparam int COL_W = 4;

  typedef logic [CRD_W-1:0] crd_t;
  typedef logic [COL_W-1:0] col_t;

  typedef struct packed {
    logic en;
    logic flip;
    crd_t x;
    crd_t y;
  } shadow_t;

  typedef struct packed {
    logic vld;
    col_t r;
    col_t g;
    col_t b;
  } pix_t;
endpackage

// File: rtl/sprite_layer_if.sv
// Animation control bundle between the sprite
// layer and its frame counter.
interface sprite_layer_if #(
  parameter int NUM_FRAMES = 1
);
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic          frame_start;
  logic          anim_en;
  logic [FW-1:0] frame_idx;

  modport master (
    output frame_start,
    output anim_en,
    input  frame_idx
  );

  modport slave (
    input  frame_start,
    input  anim_en,
    output frame_idx
  );
endinterface

// File: rtl/sprite_anim_ctr.sv
// Animation divider and frame index, stepped once
// per video frame while animation is enabled.
module sprite_anim_ctr #(
  parameter int NUM_FRAMES = 1,
  parameter int FRAME_DIV  = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  sprite_layer_if.slave anim
);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [FW-1:0] frm_q, frm_d;

  always_comb begin
    div_d = div_q;
    frm_d = frm_q;
    if (anim.frame_start && anim.anim_en) begin
      if (div_q == DW'(FRAME_DIV - 1)) begin
        div_d = '0;
        if (frm_q == FW'(NUM_FRAMES - 1)) frm_d = '0;
        else frm_d = frm_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      frm_q <= '0;
    end else begin
      div_q <= div_d;
      frm_q <= frm_d;
    end
  end

  assign anim.frame_idx = frm_q;
endmodule

// File: rtl/sprite_layer.sv
// Scaled, mirrored, animated sprite overlay fed by an
// external synchronous ROM and combinational palette.
module sprite_layer
  import sprite_pkg::*;
#(
  parameter int         SPR_W      = 50,
  parameter int         SPR_H      = 50,
  parameter int         SCALE_LOG2 = 0,
  parameter int         NUM_FRAMES = 1,
  parameter int         FRAME_DIV  = 8,
  parameter int         ADDR_W     = 12,
  parameter logic [3:0] TRANSP_IDX = 4'h0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  crd_t              DrawX,
  input  crd_t              DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  crd_t              pos_x,
  input  crd_t              pos_y,
  input  logic              sprite_en,
  input  logic              flip_h,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_address,
  input  col_t              rom_q,
  output col_t              pal_idx,
  input  col_t              pal_red,
  input  col_t              pal_green,
  input  col_t              pal_blue,
  output col_t              red,
  output col_t              green,
  output col_t              blue,
  output logic              pix_valid
);
  localparam int BW = SPR_W << SCALE_LOG2;
  localparam int BH = SPR_H << SCALE_LOG2;

  sprite_layer_if #(.NUM_FRAMES(NUM_FRAMES)) anim_if ();

  assign anim_if.frame_start = frame_start;
  assign anim_if.anim_en     = anim_en;

  sprite_anim_ctr #(
    .NUM_FRAMES(NUM_FRAMES),
    .FRAME_DIV (FRAME_DIV)
  ) u_anim (
    .clk_i(vga_clk),
    .rst_i(reset),
    .anim (anim_if.slave)
  );

  shadow_t shd_q, shd_d;
  pix_t    pix_q, pix_d;
  logic    ibx_q, blk_q;

  always_comb begin
    shd_d = shd_q;
    if (frame_start) begin
      shd_d = '{en: sprite_en, flip: flip_h, x: pos_x, y: pos_y};
    end
  end

  // 11-bit compares so a box hanging off the right/bottom never wraps
  logic [10:0] x11, y11, px11, py11;
  logic [10:0] dx, dy, col, row, colf;
  logic        in_box;

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign px11 = {1'b0, shd_q.x};
  assign py11 = {1'b0, shd_q.y};

  assign in_box = shd_q.en
               && (x11 >= px11) && (x11 < px11 + 11'(BW))
               && (y11 >= py11) && (y11 < py11 + 11'(BH));

  assign dx   = x11 - px11;
  assign dy   = y11 - py11;
  assign col  = dx >> SCALE_LOG2;
  assign row  = dy >> SCALE_LOG2;
  assign colf = shd_q.flip ? 11'(SPR_W - 1) - col : col;

  logic [ADDR_W-1:0] base;
  assign base = ADDR_W'(anim_if.frame_idx) * ADDR_W'(SPR_W * SPR_H);

  assign rom_address = in_box
    ? base + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(colf)
    : '0;

  assign pal_idx = rom_q;

  always_comb begin
    pix_d = '0;
    if (ibx_q && blk_q && (rom_q != TRANSP_IDX)) begin
      pix_d = '{vld: 1'b1, r: pal_red, g: pal_green, b: pal_blue};
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      shd_q <= '0;
      ibx_q <= 1'b0;
      blk_q <= 1'b0;
      pix_q <= '0;
    end else begin
      shd_q <= shd_d;
      ibx_q <= in_box;
      blk_q <= blank;
      pix_q <= pix_d;
    end
  end

  assign red       = pix_q.r;
  assign green     = pix_q.g;
  assign blue      = pix_q.b;
  assign pix_valid = pix_q.vld;
endmodule

// File: tb/tb_sprite_layer.sv
// Two sprite_layer instances (animated 1x, static 2x) on shared
// inputs, checked against a per-pixel reference model.
module tb_sprite_layer;
  import sprite_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, blank, frame_start;
  logic sprite_en, flip_h, anim_en;
  crd_t DrawX, DrawY, pos_x, pos_y;

  logic [12:0] addr_a;
  logic [11:0] addr_b;
  col_t qa, qb, pia, pib;
  col_t ra, ga, ba, rb, gb, bb;
  logic va, vb;

  always_ff @(posedge clk) begin
    qa <= addr_a[3:0] ^ 4'h5;
    qb <= addr_b[3:0] ^ 4'h5;
  end

  sprite_layer #(
    .NUM_FRAMES(3), .FRAME_DIV(2), .ADDR_W(13)
  ) dut_a (
    .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .sprite_en(sprite_en),
    .flip_h(flip_h), .anim_en(anim_en),
    .rom_address(addr_a), .rom_q(qa), .pal_idx(pia),
    .pal_red(pia), .pal_green(~pia), .pal_blue(pia + 4'd3),
    .red(ra), .green(ga), .blue(ba), .pix_valid(va)
  );

  sprite_layer #(
    .SCALE_LOG2(1), .ADDR_W(12)
  ) dut_b (
    .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .sprite_en(sprite_en),
    .flip_h(flip_h), .anim_en(anim_en),
    .rom_address(addr_b), .rom_q(qb), .pal_idx(pib),
    .pal_red(pib), .pal_green(~pib), .pal_blue(pib + 4'd3),
    .red(rb), .green(gb), .blue(bb), .pix_valid(vb)
  );

  int tests = 0;
  int fails = 0;

  // reference state: what each frame_start latched, and how many
  // animated frame_starts have happened since reset
  int m_en = 0, m_flip = 0, m_px = 0, m_py = 0, m_n = 0;
  logic [12:0] pa = '0, pb = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_box(input int s, input int frm,
                                  output bit inb, output int addr);
    int sz, x, y, c, r;
    sz   = 1 << s;
    x    = int'(DrawX);
    y    = int'(DrawY);
    inb  = (m_en != 0) && x >= m_px && x < m_px + 50 * sz
        && y >= m_py && y < m_py + 50 * sz;
    addr = 0;
    if (inb) begin
      c = (x - m_px) / sz;
      r = (y - m_py) / sz;
      if (m_flip != 0) c = 49 - c;
      addr = frm * 2500 + r * 50 + c;
    end
  endfunction

  function automatic logic [12:0] ref_pix(input bit inb, input int addr);
    logic [3:0] q;
    q = 4'(addr) ^ 4'h5;
    if (inb && blank && q != 4'h0) return {1'b1, q, ~q, q + 4'd3};
    return '0;
  endfunction

  task automatic step();
    bit ia, ib;
    int aa, ab;
    logic [12:0] ea, eb;
    #1;
    ref_box(0, (m_n / 2) % 3, ia, aa);
    ref_box(1, 0, ib, ab);
    chk("addr_a", 32'(addr_a), aa);
    chk("addr_b", 32'(addr_b), ab);
    ea = ref_pix(ia, aa);
    eb = ref_pix(ib, ab);
    if (reset) begin
      pa = '0; pb = '0; ea = '0; eb = '0;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_en = 0; m_flip = 0; m_px = 0; m_py = 0; m_n = 0;
    end else if (frame_start) begin
      m_en = int'(sprite_en); m_flip = int'(flip_h);
      m_px = int'(pos_x); m_py = int'(pos_y);
      if (anim_en) m_n++;
    end
    chk("pix_a", 32'({va, ra, ga, ba}), int'(pa));
    chk("pix_b", 32'({vb, rb, gb, bb}), int'(pb));
    pa = ea;
    pb = eb;
  endtask

  task automatic fs(input int x, input int y, input bit en, input bit fl);
    pos_x = crd_t'(x); pos_y = crd_t'(y);
    sprite_en = en; flip_h = fl; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic at(input int x, input int y);
    DrawX = crd_t'(x); DrawY = crd_t'(y);
    step();
  endtask

  int frm_tbl[6] = '{0, 1, 1, 2, 2, 0};

  initial begin
    reset = 1'b1; blank = 1'b1; frame_start = 1'b0;
    sprite_en = 1'b0; flip_h = 1'b0; anim_en = 1'b0;
    DrawX = '0; DrawY = '0; pos_x = '0; pos_y = '0;
    @(posedge clk);
    #1;
    step();
    chk("rst_valid", 32'(va), 0);
    reset = 1'b0;

    // basic placement at (100,50)
    fs(100, 50, 1'b1, 1'b0);
    at(100, 50);
    chk("corner0", 32'(addr_a), 0);
    at(149, 99);
    chk("corner2499", 32'(addr_a), 2499);
    at(150, 99); at(0, 0); at(0, 0);

    // 2x scaling from the origin
    fs(0, 0, 1'b1, 1'b0);
    at(3, 5);
    chk("scale_101", 32'(addr_b), 101);
    at(100, 5);
    chk("scale_out", 32'(addr_b), 0);
    at(99, 99); at(0, 0); at(0, 0);

    // mirrored, with mid-frame flip change ignored
    fs(0, 0, 1'b1, 1'b1);
    at(0, 0);
    chk("flip_49", 32'(addr_a), 49);
    flip_h = 1'b0;
    at(0, 0);
    chk("flip_hold", 32'(addr_a), 49);
    fs(0, 0, 1'b1, 1'b0);
    at(0, 0);
    chk("flip_off", 32'(addr_a), 0);

    // blanking and transparent texels inside the box
    blank = 1'b0;
    at(1, 0); at(2, 0);
    blank = 1'b1;
    at(5, 0); at(6, 0); at(7, 0);

    // box hanging off the right edge
    fs(620, 0, 1'b1, 1'b0);
    for (int x = 618; x < 640; x++) at(x, 3);
    at(0, 3);
    chk("no_wrap", 32'(addr_a), 0);
    at(1, 3); at(1, 3);

    // reset in the middle of a drawn line
    fs(0, 0, 1'b1, 1'b0);
    at(1, 1); at(2, 1);
    reset = 1'b1;
    at(3, 1);
    reset = 1'b0;
    at(4, 1);
    chk("rst_mid_v", 32'(va), 0);
    at(6, 1); at(7, 1);

    // reset wins over a coincident frame_start
    reset = 1'b1;
    fs(0, 0, 1'b1, 1'b0);
    reset = 1'b0;
    at(1, 1); at(2, 1); at(3, 1);

    // animation: frame index after each of six pulses
    anim_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fs(0, 0, 1'b1, 1'b0);
      at(0, 0);
      chk("anim_frame", 32'(addr_a), frm_tbl[i] * 2500);
    end
    fs(0, 0, 1'b1, 1'b0);
    fs(0, 0, 1'b1, 1'b0);
    anim_en = 1'b0;
    at(1, 1);
    chk("anim_1_off", 32'(addr_a), 2500 + 51);
    fs(0, 0, 1'b1, 1'b0);
    at(1, 1);
    chk("anim_hold", 32'(addr_a), 2500 + 51);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      frame_start = ($urandom_range(0, 39) == 0);
      anim_en     = 1'($urandom);
      sprite_en   = ($urandom_range(0, 7) != 0);
      flip_h      = 1'($urandom);
      pos_x       = crd_t'($urandom_range(0, SCR_W + 60));
      pos_y       = crd_t'($urandom_range(0, SCR_H + 40));
      blank       = ($urandom_range(0, 6) != 0);
      if ($urandom_range(0, 9) < 7) begin
        DrawX = crd_t'(m_px + int'($urandom_range(0, 110)) - 5);
        DrawY = crd_t'(m_py + int'($urandom_range(0, 110)) - 5);
        if (m_px + 110 > 1023 || m_px < 5) DrawX = crd_t'($urandom_range(0, 1023));
        if (m_py + 110 > 1023 || m_py < 5) DrawY = crd_t'($urandom_range(0, 1023));
      end else begin
        DrawX = crd_t'($urandom_range(0, 1023));
        DrawY = crd_t'($urandom_range(0, 1023));
      end
      step();
    end
    reset = 1'b0;
    frame_start = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
